// File: rtl/dsmdm_dma_pkg.sv
// dsmdm_dma_pkg
// Shared constants and types for the dsmdm DMA responder:
//   - register-bus data width
//   - dsmdm register map addresses used by the DMA
//   - FSM state encoding (also exported on the debug port)
package dsmdm_dma_pkg;

  localparam int DSMDM_DW = 32;

  localparam logic [31:0] DSMDM_ADDR_CTRL  = 32'h0;
  localparam logic [31:0] DSMDM_ADDR_DIN0  = 32'h3;
  localparam logic [31:0] DSMDM_ADDR_DOUT0 = 32'h5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_DIN    = 3'd1,
    ST_ACK_DIN   = 3'd2,
    ST_WAIT_DIN  = 3'd3,
    ST_RD_DOUT   = 3'd4,
    ST_ACK_DOUT  = 3'd5,
    ST_WAIT_DOUT = 3'd6
  } dma_state_e;

endpackage

// File: rtl/dsmdm_dma_fifo.sv
// dsmdm_dma_fifo
// Synchronous FIFO, depth 2**AW, with first-word-visible head output.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_push, i_data    write request and data (ignored when full unless a pop
//                     happens in the same cycle)
//   i_pop             read request (ignored when empty)
//   o_head            current head word (valid when !o_empty)
//   o_full, o_empty   occupancy status
module dsmdm_dma_fifo
  import dsmdm_dma_pkg::*;
#(
  parameter int AW = 3,
  parameter int DW = DSMDM_DW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic          o_full,
  output logic          o_empty
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;

  logic w_do_push;
  logic w_do_pop;

  // Pointers carry one extra bit: equal low bits with differing MSB means
  // the writer has lapped the reader exactly once.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // A push into a full FIFO is accepted when the head leaves in the same
  // cycle, so the occupancy stays put.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_head = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/dsmdm_dma.sv
// dsmdm_dma
// DMA responder and register-bus initiator for the dsmdm sigma-delta modem.
// A din request writes the next TX sample into the DSM input register; a
// dout request reads the DSDM/CIC output register into the RX FIFO. Every
// request is closed by a one-cycle registered ack.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   enable                         allows new transactions to start
//   clr_flags                      clears underrun / overrun
//   src_valid/src_ready/src_data   TX sample stream in
//   snk_valid/snk_ready/snk_data   RX sample stream out
//   din_dma_req, dout_dma_req      requests from dsmdm (asynchronous-ish)
//   din_dma_ack, dout_dma_ack      registered acknowledge pulses
//   we, sel, addr, wdata, rdata    dsmdm register bus
//   underrun, overrun              sticky error flags
//   dbg_state                      current FSM state (dma_state_e encoding)
//
// Stream handshakes: a word moves on a clock edge where valid and ready are
// both high; valid never depends on ready, and data is stable while valid.
module dsmdm_dma
  import dsmdm_dma_pkg::*;
#(
  parameter int          FIFO_AW   = 3,
  parameter logic [31:0] DIN_ADDR  = DSMDM_ADDR_DIN0,
  parameter logic [31:0] DOUT_ADDR = DSMDM_ADDR_DOUT0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clr_flags,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [31:0] src_data,
  output logic        snk_valid,
  input  logic        snk_ready,
  output logic [31:0] snk_data,
  input  logic        din_dma_req,
  input  logic        dout_dma_req,
  output logic        din_dma_ack,
  output logic        dout_dma_ack,
  output logic        we,
  output logic        sel,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        underrun,
  output logic        overrun,
  output logic [2:0]  dbg_state
);

  // Request synchronisers
  logic r_din_s1, r_din_s2;
  logic r_dout_s1, r_dout_s2;

  dma_state_e r_state;
  dma_state_e w_state_nxt;

  logic [31:0] r_last;
  logic        r_din_ack;
  logic        r_dout_ack;
  logic        r_underrun;
  logic        r_overrun;

  // FIFO interconnect
  logic        w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [31:0] w_tx_head;
  logic        w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [31:0] w_rx_head;

  logic w_underrun_set;
  logic w_overrun_set;

  dsmdm_dma_fifo #(.AW(FIFO_AW), .DW(DSMDM_DW)) u_tx_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_tx_push),
    .i_data  (src_data),
    .i_pop   (w_tx_pop),
    .o_head  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  dsmdm_dma_fifo #(.AW(FIFO_AW), .DW(DSMDM_DW)) u_rx_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_rx_push),
    .i_data  (rdata),
    .i_pop   (w_rx_pop),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // Stream side
  assign src_ready = !w_tx_full;
  assign w_tx_push = src_valid && !w_tx_full;
  assign snk_valid = !w_rx_empty;
  assign snk_data  = w_rx_head;
  assign w_rx_pop  = !w_rx_empty && snk_ready;

  // Transaction side: the TX head leaves only when it is actually written;
  // the RX push is attempted every read and the FIFO drops it when full.
  assign w_tx_pop       = (r_state == ST_WR_DIN) && !w_tx_empty;
  assign w_underrun_set = (r_state == ST_WR_DIN) && w_tx_empty;
  assign w_rx_push      = (r_state == ST_RD_DOUT);
  assign w_overrun_set  = (r_state == ST_RD_DOUT) && w_rx_full && !w_rx_pop;

  // Next-state logic. din has priority; enable only gates the IDLE exit so
  // an ongoing transaction always runs through its WAIT state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable && r_din_s2)       w_state_nxt = ST_WR_DIN;
        else if (enable && r_dout_s2) w_state_nxt = ST_RD_DOUT;
      end
      ST_WR_DIN:    w_state_nxt = ST_ACK_DIN;
      ST_ACK_DIN:   w_state_nxt = ST_WAIT_DIN;
      ST_WAIT_DIN:  if (!r_din_s2) w_state_nxt = ST_IDLE;
      ST_RD_DOUT:   w_state_nxt = ST_ACK_DOUT;
      ST_ACK_DOUT:  w_state_nxt = ST_WAIT_DOUT;
      ST_WAIT_DOUT: if (!r_dout_s2) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Register bus: driven only in the single bus-cycle states. rdata is a
  // combinational decode inside dsmdm, so it is valid within RD_DOUT.
  always_comb begin
    we    = 1'b0;
    sel   = 1'b0;
    addr  = '0;
    wdata = '0;
    case (r_state)
      ST_WR_DIN: begin
        we    = 1'b1;
        sel   = 1'b1;
        addr  = DIN_ADDR;
        wdata = w_tx_empty ? r_last : w_tx_head;
      end
      ST_RD_DOUT: begin
        sel  = 1'b1;
        addr = DOUT_ADDR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_din_s1   <= 1'b0;
      r_din_s2   <= 1'b0;
      r_dout_s1  <= 1'b0;
      r_dout_s2  <= 1'b0;
      r_state    <= ST_IDLE;
      r_last     <= '0;
      r_din_ack  <= 1'b0;
      r_dout_ack <= 1'b0;
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_din_s1  <= din_dma_req;
      r_din_s2  <= r_din_s1;
      r_dout_s1 <= dout_dma_req;
      r_dout_s2 <= r_dout_s1;
      r_state   <= w_state_nxt;

      if (w_tx_pop) r_last <= w_tx_head;

      // Dedicated ack flops keep the pulses free of state-decode glitches.
      r_din_ack  <= (r_state == ST_WR_DIN);
      r_dout_ack <= (r_state == ST_RD_DOUT);

      // Set dominates clear so no error event is lost.
      if (w_underrun_set)  r_underrun <= 1'b1;
      else if (clr_flags)  r_underrun <= 1'b0;
      if (w_overrun_set)   r_overrun  <= 1'b1;
      else if (clr_flags)  r_overrun  <= 1'b0;
    end
  end

  assign din_dma_ack  = r_din_ack;
  assign dout_dma_ack = r_dout_ack;
  assign underrun     = r_underrun;
  assign overrun      = r_overrun;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_dsmdm_dma.sv
// tb_dsmdm_dma
// Self-checking bench for dsmdm_dma: models dsmdm request/ack behaviour and
// its register decode, keeps expected bus writes and RX words in queues.
module tb_dsmdm_dma;
  import dsmdm_dma_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst, enable, clr_flags;
  logic        src_valid, src_ready;
  logic [31:0] src_data;
  logic        snk_valid, snk_ready;
  logic [31:0] snk_data;
  logic        din_dma_req, dout_dma_req, din_dma_ack, dout_dma_ack;
  logic        we, sel;
  logic [31:0] addr, wdata, rdata;
  logic        underrun, overrun;
  logic [2:0]  dbg_state;

  logic [31:0] dout_val;

  always #5 clk = ~clk;

  // dsmdm output register decode, combinational from addr/sel
  assign rdata = (sel && !we && addr == 32'h5) ? dout_val : 32'h0;

  dsmdm_dma dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .clr_flags    (clr_flags),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_data     (src_data),
    .snk_valid    (snk_valid),
    .snk_ready    (snk_ready),
    .snk_data     (snk_data),
    .din_dma_req  (din_dma_req),
    .dout_dma_req (dout_dma_req),
    .din_dma_ack  (din_dma_ack),
    .dout_dma_ack (dout_dma_ack),
    .we           (we),
    .sel          (sel),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .underrun     (underrun),
    .overrun      (overrun),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_wr_q[$];
  logic [31:0] exp_rx_q[$];
  logic [31:0] tx_model[$];
  logic [1:0]  op_log[$];
  logic [31:0] last_wr;
  logic        exp_under, exp_over;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          wr_cnt = 0, rd_cnt = 0, din_ack_cnt = 0, dout_ack_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (sel && we) begin
        op_log.push_back(2'd1);
        wr_cnt++;
        chk("wr_addr", addr, 32'h3);
        chk("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
        if (exp_wr_q.size() != 0) chk("wr_data", wdata, exp_wr_q.pop_front());
      end
      if (sel && !we) begin
        op_log.push_back(2'd2);
        rd_cnt++;
        chk("rd_addr", addr, 32'h5);
      end
      if (din_dma_ack)  din_ack_cnt++;
      if (dout_dma_ack) dout_ack_cnt++;
      if (snk_valid && snk_ready) begin
        chk("rx_expected", 32'(exp_rx_q.size() != 0), 32'd1);
        if (exp_rx_q.size() != 0) chk("rx_data", snk_data, exp_rx_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_tx(input logic [31:0] d);
    chk("src_ready", 32'(src_ready), 32'd1);
    src_valid = 1'b1;
    src_data  = d;
    @(posedge clk); #1;
    src_valid = 1'b0;
    tx_model.push_back(d);
  endtask

  // Wait in IDLE-to-IDLE steps for one full request; checks latencies.
  task automatic do_req(input bit is_din);
    int n;
    if (is_din) begin
      if (tx_model.size() != 0) last_wr = tx_model.pop_front();
      else exp_under = 1'b1;
      exp_wr_q.push_back(last_wr);
      din_dma_req = 1'b1;
    end else begin
      if (exp_rx_q.size() < 8) exp_rx_q.push_back(dout_val);
      else exp_over = 1'b1;
      dout_dma_req = 1'b1;
    end
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!(is_din ? din_dma_ack : dout_dma_ack) && n < 20);
    chk(is_din ? "din_ack_lat" : "dout_ack_lat", 32'(n), 32'd4);
    @(posedge clk); #1;
    chk("ack_width", 32'(is_din ? din_dma_ack : dout_dma_ack), 32'd0);
    if (is_din) din_dma_req = 1'b0; else dout_dma_req = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (dbg_state != ST_IDLE && n < 20);
    chk("idle_lat", 32'(n), 32'd3);
    chk("underrun", 32'(underrun), 32'(exp_under));
    chk("overrun", 32'(overrun), 32'(exp_over));
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    exp_under = 1'b0;
    exp_over  = 1'b0;
    chk("clr_underrun", 32'(underrun), 32'd0);
    chk("clr_overrun", 32'(overrun), 32'd0);
  endtask

  task automatic drain_rx();
    int n;
    snk_ready = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (snk_valid && n < 30);
    snk_ready = 1'b0;
    chk("rx_drained", 32'(exp_rx_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, base_acks, base_wr;
    rst = 1'b1; enable = 1'b1; clr_flags = 1'b0;
    src_valid = 1'b0; src_data = '0; snk_ready = 1'b0;
    din_dma_req = 1'b0; dout_dma_req = 1'b0; dout_val = '0;
    last_wr = '0; exp_under = 1'b0; exp_over = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_src_ready", 32'(src_ready), 32'd1);
    chk("rst_snk_valid", 32'(snk_valid), 32'd0);
    chk("rst_acks", 32'({din_dma_ack, dout_dma_ack}), 32'd0);
    chk("rst_bus", 32'({we, sel}), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_flags", 32'({underrun, overrun}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single din transfer, then underrun repeating the last sample
    push_tx(32'h12345678);
    do_req(1'b1);
    push_tx(32'hA5A5A5A5);
    do_req(1'b1);
    do_req(1'b1);
    pulse_clr();

    // fill TX to its depth, then empty it with din requests
    for (int i = 0; i < 8; i++) push_tx($urandom);
    chk("tx_full", 32'(src_ready), 32'd0);
    for (int i = 0; i < 8; i++) do_req(1'b1);
    chk("tx_not_full", 32'(src_ready), 32'd1);
    do_req(1'b1);
    pulse_clr();

    // simultaneous requests: din first, dout after din req falls
    push_tx(32'hCAFE0001);
    dout_val = 32'h0BADF00D;
    last_wr = tx_model.pop_front();
    exp_wr_q.push_back(last_wr);
    exp_rx_q.push_back(dout_val);
    op_log.delete();
    base_acks = din_ack_cnt + dout_ack_cnt;
    din_dma_req = 1'b1; dout_dma_req = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!din_dma_ack && n < 20);
    chk("sim_din_lat", 32'(n), 32'd4);
    @(posedge clk); #1;
    din_dma_req = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!dout_dma_ack && n < 20);
    chk("sim_dout_lat", 32'(n), 32'd5);
    @(posedge clk); #1;
    dout_dma_req = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (dbg_state != ST_IDLE && n < 20);
    chk("sim_idle_lat", 32'(n), 32'd3);
    chk("sim_ops", 32'(op_log.size()), 32'd2);
    if (op_log.size() == 2) begin
      chk("sim_first_op", 32'(op_log[0]), 32'd1);
      chk("sim_second_op", 32'(op_log[1]), 32'd2);
    end
    chk("sim_acks", 32'(din_ack_cnt + dout_ack_cnt - base_acks), 32'd2);
    drain_rx();

    // dout overrun: 9 reads into an 8-deep RX with the sink stalled
    base_acks = dout_ack_cnt;
    for (int i = 1; i <= 9; i++) begin
      dout_val = 32'(i);
      do_req(1'b0);
    end
    chk("ovr_acks", 32'(dout_ack_cnt - base_acks), 32'd9);
    chk("ovr_rx_depth", 32'(exp_rx_q.size()), 32'd8);
    drain_rx();
    pulse_clr();

    // enable gating: request held with enable low, then enable pulsed off
    // during the write cycle
    push_tx($urandom);
    enable = 1'b0;
    base_wr = wr_cnt;
    base_acks = din_ack_cnt;
    din_dma_req = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("en_no_write", 32'(wr_cnt - base_wr), 32'd0);
    chk("en_no_ack", 32'(din_ack_cnt - base_acks), 32'd0);
    chk("en_idle", 32'(dbg_state), 32'(ST_IDLE));
    last_wr = tx_model.pop_front();
    exp_wr_q.push_back(last_wr);
    enable = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(we && sel) && n < 20);
    chk("en_lat", 32'(n), 32'd1);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("en_ack", 32'(din_dma_ack), 32'd1);
    @(posedge clk); #1;
    chk("en_wait", 32'(dbg_state), 32'(ST_WAIT_DIN));
    din_dma_req = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (dbg_state != ST_IDLE && n < 20);
    chk("en_idle_lat", 32'(n), 32'd3);
    enable = 1'b1;

    // reset during ACK_DIN; the held request is re-served from an empty FIFO
    push_tx(32'h600DD00D);
    last_wr = tx_model.pop_front();
    exp_wr_q.push_back(last_wr);
    din_dma_req = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (dbg_state != ST_ACK_DIN && n < 20);
    chk("rm_in_ack", 32'(din_dma_ack), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rm_ack_low", 32'(din_dma_ack), 32'd0);
    chk("rm_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rm_bus", 32'({we, sel}), 32'd0);
    chk("rm_src_ready", 32'(src_ready), 32'd1);
    rst = 1'b0;
    last_wr = '0;
    exp_under = 1'b1;
    exp_over = 1'b0;
    exp_wr_q.push_back(32'h0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(we && sel) && n < 20);
    chk("rm_reserve_lat", 32'(n), 32'd3);
    @(posedge clk); #1;
    chk("rm_ack", 32'(din_dma_ack), 32'd1);
    @(posedge clk); #1;
    din_dma_req = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (dbg_state != ST_IDLE && n < 20);
    chk("rm_idle_lat", 32'(n), 32'd3);
    chk("rm_underrun", 32'(underrun), 32'(exp_under));

    repeat (2) @(posedge clk);
    #1;
    chk("wr_all_seen", 32'(exp_wr_q.size()), 32'd0);
    chk("rd_count", 32'(rd_cnt), 32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
